// File: rtl/prog_loader_if.sv
// Load/fetch bus between a program source, the loader and the core it feeds.
// The master drives the load stream and fetch address; the slave is the loader.
`timescale 1ns/1ps
interface prog_loader_if;
    logic        ld_start;
    logic [4:0]  ld_len;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  addr;
    logic [45:0] line;
    logic        core_nrst;
    logic        loaded;
    logic        ld_err;

    modport master (
        output ld_start, ld_len, ld_data, ld_valid, addr,
        input  ld_ready, line, core_nrst, loaded, ld_err
    );

    modport slave (
        input  ld_start, ld_len, ld_data, ld_valid, addr,
        output ld_ready, line, core_nrst, loaded, ld_err
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: assembles 6-byte MSB-first words into a 16 x 46-bit program
// store, holds the core in reset while loading and releases it once complete.
`timescale 1ns/1ps
module prog_loader #(
    parameter int NUM_LINES = 16
) (
    input  logic         clk,
    input  logic         nrst,
    prog_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  byte_cnt_reg, byte_cnt_next;
    logic [3:0]  line_cnt_reg, line_cnt_next;
    logic [4:0]  len_reg, len_next;
    logic [37:0] word_reg, word_next;
    logic        err_reg, err_next;
    logic        loaded_reg, loaded_next;
    logic        core_nrst_reg, core_nrst_next;

    logic [45:0] mem [NUM_LINES];
    logic [NUM_LINES-1:0] wr_sel;
    logic [45:0] wr_word;

    logic start_ok, start_bad;
    logic last_byte, last_line;
    logic ready, xfer, wr_en;

    assign start_ok  = bus.ld_start && (bus.ld_len != 5'd0) && (bus.ld_len <= 5'd16);
    assign start_bad = bus.ld_start && !start_ok;
    assign last_byte = (byte_cnt_reg == 3'd5);
    assign last_line = ({1'b0, line_cnt_reg} == (len_reg - 5'd1));

    // byte0..byte4 minus the two discarded top bits, completed by byte5
    assign wr_word = {word_reg, bus.ld_data};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_next = LOAD;
                end else if (start_bad) begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                if (start_ok) begin
                    state_next = LOAD;
                end else if (start_bad) begin
                    state_next = IDLE;
                end else if (wr_en && last_line) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    always_comb begin
        ready          = (state_reg == LOAD);
        // a start in the same cycle wins; the byte on the bus is dropped
        xfer           = ready && bus.ld_valid && !bus.ld_start;
        wr_en          = xfer && last_byte;
        loaded_next    = (state_next == DONE);
        // falls on the edge entering LOAD, rises one edge after DONE is reached
        core_nrst_next = (state_reg == DONE) && (state_next == DONE);
    end

    // ---------------- Datapath next values ----------------
    always_comb begin
        byte_cnt_next = byte_cnt_reg;
        line_cnt_next = line_cnt_reg;
        len_next      = len_reg;
        word_next     = word_reg;
        err_next      = err_reg;

        if (start_ok) begin
            byte_cnt_next = 3'd0;
            line_cnt_next = 4'd0;
            len_next      = bus.ld_len;
            err_next      = 1'b0;
        end else if (start_bad) begin
            err_next      = 1'b1;
        end else if (xfer) begin
            if (last_byte) begin
                byte_cnt_next = 3'd0;
                if (!last_line) begin
                    line_cnt_next = line_cnt_reg + 4'd1;
                end
            end else begin
                byte_cnt_next = byte_cnt_reg + 3'd1;
            end

            if (byte_cnt_reg == 3'd0) begin
                word_next = {32'd0, bus.ld_data[5:0]};
                if (bus.ld_data[7:6] != 2'b00) begin
                    err_next = 1'b1;
                end
            end else begin
                word_next = {word_reg[29:0], bus.ld_data};
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            byte_cnt_reg  <= 3'd0;
            line_cnt_reg  <= 4'd0;
            len_reg       <= 5'd0;
            word_reg      <= 38'd0;
            err_reg       <= 1'b0;
            loaded_reg    <= 1'b0;
            core_nrst_reg <= 1'b0;
        end else begin
            byte_cnt_reg  <= byte_cnt_next;
            line_cnt_reg  <= line_cnt_next;
            len_reg       <= len_next;
            word_reg      <= word_next;
            err_reg       <= err_next;
            loaded_reg    <= loaded_next;
            core_nrst_reg <= core_nrst_next;
        end
    end

    // ---------------- Program store ----------------
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (line_cnt_reg == gi[3:0]);
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                mem[i] <= 46'd0;
            end
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (wr_sel[i]) begin
                    mem[i] <= wr_word;
                end
            end
        end
    end

    assign bus.line      = mem[bus.addr];
    assign bus.ld_ready  = ready;
    assign bus.loaded    = loaded_reg;
    assign bus.core_nrst = core_nrst_reg;
    assign bus.ld_err    = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed scenarios plus randomized loads, checked
// against a line-array model of the program store and the error/handshake rules.
`timescale 1ns/1ps
module tb_prog_loader;

    logic clk = 1'b0;
    logic nrst = 1'b0;

    prog_loader_if bus ();

    prog_loader dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [47:0] words   [16];
    logic [45:0] mem_exp [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int k);
        logic [47:0] w;
        w = words[k / 6];
        return w[47 - 8 * (k % 6) -: 8];
    endfunction

    task automatic rand_words(input int n, input bit allow_top);
        for (int i = 0; i < n; i++) begin
            words[i] = {16'($urandom), 32'($urandom)};
            if (!allow_top || $urandom_range(0, 5) != 0) words[i][47:46] = 2'b00;
        end
    endtask

    task automatic chk_lines(input string tag);
        for (int i = 0; i < 16; i++) begin
            bus.addr = 4'(i);
            #1;
            chk($sformatf("%s_line%0d", tag, i), 64'(bus.line), 64'(mem_exp[i]));
        end
        @(posedge clk); #1;
    endtask

    task automatic start_pulse(input logic [4:0] len, input logic v, input logic [7:0] d);
        bus.ld_start = 1'b1;
        bus.ld_len   = len;
        bus.ld_valid = v;
        bus.ld_data  = d;
        @(posedge clk); #1;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
    endtask

    // mode 0: valid always, 1: valid every other cycle, 2: random gaps
    task automatic feed(input int from, input int to, input int mode);
        int k;
        int cyc;
        logic v;
        k = from;
        cyc = 0;
        while (k < to && cyc < 3000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            bus.ld_valid = v;
            bus.ld_data  = v ? byte_of(k) : 8'($urandom);
            @(posedge clk); #1;
            if (v) k++;
            cyc++;
        end
        bus.ld_valid = 1'b0;
        if (k < to) chk("feed_timeout", 64'(k), 64'(to));
    endtask

    task automatic run_load(input int len, input int mode, input logic start_valid);
        int cnt;
        logic e;
        start_pulse(5'(len), start_valid, 8'hFF);
        chk("start_ready", 64'(bus.ld_ready), 64'd1);
        chk("start_err", 64'(bus.ld_err), 64'd0);
        chk("start_cnrst", 64'(bus.core_nrst), 64'd0);
        chk("start_loaded", 64'(bus.loaded), 64'd0);
        if (mode == 0) begin
            cnt = 0;
            bus.ld_valid = 1'b1;
            while (!bus.loaded && cnt < 200) begin
                bus.ld_data = (cnt < 6 * len) ? byte_of(cnt) : 8'h00;
                @(posedge clk); #1;
                cnt++;
            end
            bus.ld_valid = 1'b0;
            chk("latency", 64'(cnt), 64'(6 * len));
        end else begin
            feed(0, 6 * len - 1, mode);
            chk("loaded_early", 64'(bus.loaded), 64'd0);
            feed(6 * len - 1, 6 * len, mode);
        end
        chk("done_loaded", 64'(bus.loaded), 64'd1);
        chk("done_ready", 64'(bus.ld_ready), 64'd0);
        chk("done_cnrst_low", 64'(bus.core_nrst), 64'd0);
        e = 1'b0;
        for (int i = 0; i < len; i++) begin
            mem_exp[i] = words[i][45:0];
            e |= |words[i][47:46];
        end
        chk("done_err", 64'(bus.ld_err), 64'(e));
        @(posedge clk); #1;
        chk("done_cnrst_high", 64'(bus.core_nrst), 64'd1);
        chk_lines($sformatf("load%0d", len));
    endtask

    initial begin
        bus.ld_start = 1'b0;
        bus.ld_len   = 5'd0;
        bus.ld_data  = 8'd0;
        bus.ld_valid = 1'b0;
        bus.addr     = 4'd0;
        for (int i = 0; i < 16; i++) mem_exp[i] = 46'd0;

        // reset state
        #1;
        chk("rst_ready", 64'(bus.ld_ready), 64'd0);
        chk("rst_cnrst", 64'(bus.core_nrst), 64'd0);
        chk("rst_loaded", 64'(bus.loaded), 64'd0);
        chk("rst_err", 64'(bus.ld_err), 64'd0);
        chk_lines("rst");
        nrst = 1'b1;

        // bytes offered in IDLE are ignored
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'hA5;
            @(posedge clk); #1;
            chk("idle_ready", 64'(bus.ld_ready), 64'd0);
        end
        bus.ld_valid = 1'b0;
        chk_lines("idle");

        // two-line load, valid held, then with valid toggling
        words[0] = 48'h0000_0000_0001;
        words[1] = 48'h3FFF_FFFF_FFFF;
        run_load(2, 0, 1'b0);
        for (int i = 0; i < 16; i++) mem_exp[i] = mem_exp[i];
        words[0] = 48'h0000_0000_0001;
        words[1] = 48'h3FFF_FFFF_FFFF;
        run_load(2, 1, 1'b0);

        // bytes offered in DONE are ignored
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'hFF;
            @(posedge clk); #1;
            chk("done_ignore_ready", 64'(bus.ld_ready), 64'd0);
        end
        bus.ld_valid = 1'b0;
        chk_lines("done_ignore");

        // discarded top bits set on line 0
        rand_words(2, 1'b0);
        words[0][47:40] = 8'hC0;
        run_load(2, 2, 1'b0);
        bus.addr = 4'd0;
        #1;
        chk("top_bits_line0", 64'(bus.line[45:40]), 64'd0);

        // illegal lengths
        start_pulse(5'd0, 1'b0, 8'h00);
        chk("len0_err", 64'(bus.ld_err), 64'd1);
        chk("len0_ready", 64'(bus.ld_ready), 64'd0);
        chk("len0_cnrst", 64'(bus.core_nrst), 64'd0);
        start_pulse(5'd17, 1'b0, 8'h00);
        chk("len17_err", 64'(bus.ld_err), 64'd1);
        chk("len17_ready", 64'(bus.ld_ready), 64'd0);
        chk_lines("illegal");
        rand_words(1, 1'b0);
        run_load(1, 0, 1'b0);

        // abort a 4-line load after 8 bytes; restart carries a dropped byte
        rand_words(4, 1'b1);
        start_pulse(5'd4, 1'b0, 8'h00);
        feed(0, 8, 0);
        mem_exp[0] = words[0][45:0];
        words[0] = 48'h0000_0000_0005;
        run_load(1, 0, 1'b1);
        bus.addr = 4'd0;
        #1;
        chk("abort_line0", 64'(bus.line), 64'h5);

        // randomized loads, ending with a full-length one at full rate
        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 16);
            rand_words(len, 1'b1);
            run_load(len, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        rand_words(16, 1'b0);
        run_load(16, 0, 1'b0);

        // reset in the middle of a load wipes everything
        rand_words(5, 1'b0);
        start_pulse(5'd5, 1'b0, 8'h00);
        feed(0, 20, 2);
        nrst = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) mem_exp[i] = 46'd0;
        chk("midrst_ready", 64'(bus.ld_ready), 64'd0);
        chk("midrst_cnrst", 64'(bus.core_nrst), 64'd0);
        chk("midrst_loaded", 64'(bus.loaded), 64'd0);
        chk("midrst_err", 64'(bus.ld_err), 64'd0);
        chk_lines("midrst");
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'h3C;
            @(posedge clk); #1;
            chk("postrst_ready", 64'(bus.ld_ready), 64'd0);
        end
        bus.ld_valid = 1'b0;
        chk_lines("postrst");
        rand_words(3, 1'b1);
        run_load(3, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: NUM_LINES, default 16, number of 46-bit program lines held; fixed at 16 in this release.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 nrst  input  1  asynchronous, active-low reset.
REQ-004 ld_start  input  1  one-cycle pulse; begins, or restarts, a program load.
REQ-005 ld_len  input  5  number of lines to load, sampled when ld_start is accepted; legal range 1..16.
REQ-006 ld_data  input  8  load byte.
REQ-007 ld_valid  input  1  ld_data is valid this cycle.
REQ-008 ld_ready  output  1  loader accepts a byte this cycle.
REQ-009 addr  input  4  core fetch address (next_inst).
REQ-010 line  output  46  program line at addr: {PC[45:42], cond[41:40], inst[39:36], arg1[35:24], arg2[23:12], arg3[11:0]}.
REQ-011 core_nrst  output  1  active-low reset to the core; registered.
REQ-012 loaded  output  1  a complete program is resident.
REQ-013 ld_err  output  1  sticky error flag; cleared only by an accepted ld_start or by nrst.

Function
REQ-014 The block SHALL implement three states: IDLE, LOAD and DONE.
REQ-015 Storage SHALL be NUM_LINES x 46-bit registers, mem[0..15].
REQ-016 line SHALL equal mem[addr] combinationally in every state.
REQ-017 Transfer rule: a byte transfers when ld_valid and ld_ready are both 1 at a rising clk edge.
REQ-018 ld_ready SHALL be 1 only in LOAD; ld_valid in IDLE or DONE SHALL be ignored.
REQ-019 IDLE/DONE -> LOAD on ld_start with ld_len in 1..16: clear the byte counter (0..5) and the line counter (0..15); latch ld_len; clear loaded and ld_err.
REQ-020 On ld_start with ld_len = 0 or ld_len > 16: stay in or go to IDLE; set ld_err; leave mem unchanged.
REQ-021 Each line SHALL be 6 bytes, sent MSB first: byte0 = bits[47:40], byte5 = bits[7:0] of a 48-bit word.
REQ-022 Bits [47:46] SHALL be discarded; if either is 1, ld_err SHALL be set and loading SHALL continue.
REQ-023 On transfer of byte5: write the assembled word[45:0] to mem[line counter] at that same edge, increment the line counter, and reset the byte counter to 0.
REQ-024 LOAD -> DONE at the edge that writes line (ld_len-1); loaded SHALL be 1 from the next cycle.
REQ-025 ld_start during LOAD SHALL abort the load and restart per REQ-019/020; lines already written SHALL keep their new contents, and the partial word SHALL be discarded.
REQ-026 ld_start and a valid transfer in the same cycle: ld_start SHALL win and the byte SHALL be dropped.
REQ-027 Lines >= ld_len SHALL retain their previous contents.
REQ-028 core_nrst SHALL be 0 in IDLE and LOAD, and 1 in DONE.
REQ-029 core_nrst SHALL go to 0 at the edge where LOAD is entered; it rises one edge after DONE is entered.
REQ-030 Load latency: a 16-line load with ld_valid held at 1 SHALL take exactly 96 transfer cycles; loaded rises on the clk edge after the 96th transfer.
REQ-031 The line counter SHALL never wrap, because DONE is reached at ld_len.

Reset
REQ-032 While nrst = 0: state = IDLE, all mem lines = 0, counters = 0, ld_ready = 0, core_nrst = 0, loaded = 0, ld_err = 0.
REQ-033 Reset asserted mid-load SHALL discard all progress, including lines already written.
REQ-034 After nrst is released, the block SHALL stay in IDLE until a legal ld_start.

Verification
REQ-035 Reset, then read addr 0..15 -> line = 46'h0 for every addr; core_nrst = 0; ld_ready = 0.
REQ-036 ld_start with ld_len = 2, then bytes 00 00 00 00 00 01, 3F FF FF FF FF FF -> mem[0] = 46'h1, mem[1] = 46'h3FFF_FFFF_FFFF; loaded = 1; core_nrst = 1 one cycle after DONE; ld_err = 0.
REQ-037 Same 2-line load with ld_valid toggling every other cycle -> same contents; transfers occur only when valid and ready; 12 transfers total.
REQ-038 Byte0 = 0xC0 on line 0 -> ld_err = 1; mem[0][45:40] = 0; load completes normally.
REQ-039 ld_start with ld_len = 0 -> ld_err = 1, state IDLE, core_nrst = 0; a following ld_start with ld_len = 1 clears ld_err.
REQ-040 Abort after 8 bytes of a 4-line load with ld_start (ld_len = 1), then 6 bytes 00 00 00 00 00 05 -> mem[0] = 46'h5, mem[1] holds the prior value; also nrst pulsed mid-load -> all lines = 0, IDLE.
